// File: rtl/irq_pkg.sv
// Shared widths and vector types for the interrupt pending latch and its 8-input encoder.
// No logic; constants and typedefs only.
package irq_pkg;
    localparam int IRQ_WIDTH = 8;
    localparam int IRQ_IDX_W = 3;

    typedef logic [IRQ_WIDTH-1:0] irq_vec_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;
endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/mask/acknowledge bundle between the pending latch and its driver/consumer.
// Overflow signals exist only when IRQ_PENDING_LATCH_OVERFLOW_EN is defined.
interface irq_pending_latch_if;
    import irq_pkg::*;

    irq_vec_t req_in;
    irq_vec_t mask_in;
    logic     ack_valid;
    irq_idx_t ack_index;
    irq_vec_t in_vector;
    logic     any_pending;
    irq_vec_t pending_raw;
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
    irq_vec_t overflow;
    logic     ovf_clear;

    modport master (
        output req_in, mask_in, ack_valid, ack_index, ovf_clear,
        input  in_vector, any_pending, pending_raw, overflow
    );
    modport slave (
        input  req_in, mask_in, ack_valid, ack_index, ovf_clear,
        output in_vector, any_pending, pending_raw, overflow
    );
`else
    modport master (
        output req_in, mask_in, ack_valid, ack_index,
        input  in_vector, any_pending, pending_raw
    );
    modport slave (
        input  req_in, mask_in, ack_valid, ack_index,
        output in_vector, any_pending, pending_raw
    );
`endif
endinterface

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the request lines.
// Latency: rise is combinational from req_in against the previous-cycle sample.
// Backpressure: none; samples every cycle.
module irq_edge_detect
    import irq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  irq_vec_t req_in,
    output irq_vec_t rise
);
    irq_vec_t req_prev;

    // Clearing to 0 makes a line already high at reset release count as one event.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev <= '0;
        end else begin
            req_prev <= req_in;
        end
    end

    assign rise = req_in & ~req_prev;
endmodule

// File: rtl/irq_pending_latch.sv
// Sticky per-line pending latch feeding the 8-input priority encoder; optional lost-event
// flags under IRQ_PENDING_LATCH_OVERFLOW_EN. Latency: 1 cycle req->in_vector, 0 cycles mask->in_vector.
// Backpressure: none; one acknowledge per cycle, any number of simultaneous rises.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int WIDTH = IRQ_WIDTH,
    parameter int IDX_W = IRQ_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    irq_pending_latch_if.slave  bus
);
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] masked;
    logic [IDX_W-1:0] ack_idx;

    assign ack_idx = bus.ack_index;

    irq_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .req_in (bus.req_in),
        .rise   (rise)
    );

    always_comb begin
        clr = '0;
        if (bus.ack_valid) begin
            clr[ack_idx] = 1'b1;
        end
    end

    // OR-ing rise after the clear makes a same-cycle new event win over the acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

    assign masked          = pending & ~bus.mask_in;
    assign bus.in_vector   = masked;
    assign bus.any_pending = |masked;
    assign bus.pending_raw = pending;

`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
    logic [WIDTH-1:0] lost;
    logic [WIDTH-1:0] overflow_q;

    // A rise is only lost if the bit stays pending, i.e. it is not being acknowledged now.
    assign lost = rise & pending & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= (bus.ovf_clear ? '0 : overflow_q) | lost;
        end
    end

    assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: per-line event model checked every cycle plus literal pins.
// Build with or without IRQ_PENDING_LATCH_OVERFLOW_EN.
module tb_irq_pending_latch;
    import irq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_pending_latch_if bus ();

`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
    logic ovf_clr;
    assign bus.ovf_clear = ovf_clr;
`endif

    irq_pending_latch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
        end
    endtask

    // Line-level model: each line remembers its last level, whether an event waits, and whether one was lost.
    bit m_on = 1'b0;
    bit m_level [8];
    bit m_pend  [8];
    bit m_lost  [8];

    always @(posedge clk) begin
        bit event_now;
        bit acked;
        bit clr_ovf;
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
        clr_ovf = ovf_clr;
`else
        clr_ovf = 1'b0;
`endif
        if (rst) begin
            m_on <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                m_level[i] <= 1'b0;
                m_pend[i]  <= 1'b0;
                m_lost[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                event_now = bus.req_in[i] && !m_level[i];
                acked     = bus.ack_valid && (int'(bus.ack_index) == i);
                m_level[i] <= bus.req_in[i];
                if (event_now) begin
                    m_pend[i] <= 1'b1;
                    m_lost[i] <= (m_pend[i] && !acked) || (m_lost[i] && !clr_ovf);
                end else begin
                    if (acked) m_pend[i] <= 1'b0;
                    if (clr_ovf) m_lost[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_raw;
        logic [7:0] e_ovf;
        if (m_on) begin
            for (int i = 0; i < 8; i++) begin
                e_raw[i] = m_pend[i];
                e_ovf[i] = m_lost[i];
            end
            chk("model_pending_raw", bus.pending_raw, e_raw);
            chk("model_in_vector", bus.in_vector, e_raw & ~bus.mask_in);
            chk("model_any_pending", {7'd0, bus.any_pending}, {7'd0, |(e_raw & ~bus.mask_in)});
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
            chk("model_overflow", bus.overflow, e_ovf);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input int idx);
        bus.ack_valid = 1'b1;
        bus.ack_index = irq_idx_t'(idx);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_in    = 8'h00;
        bus.mask_in   = 8'h00;
        bus.ack_valid = 1'b0;
        bus.ack_index = '0;
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
        ovf_clr = 1'b0;
`endif
        step();
        chk("reset_in_vector", bus.in_vector, 8'h00);
        chk("reset_pending_raw", bus.pending_raw, 8'h00);
        chk("reset_any_pending", {7'd0, bus.any_pending}, 8'h00);
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
        chk("reset_overflow", bus.overflow, 8'h00);
`endif
        rst = 1'b0;
        step();

        // Single pulse, then acknowledge.
        bus.req_in = 8'h01; step();
        chk("pulse_in_vector", bus.in_vector, 8'h01);
        chk("pulse_any_pending", {7'd0, bus.any_pending}, 8'h01);
        bus.req_in = 8'h00; ack(0); step();
        bus.ack_valid = 1'b0;
        chk("ack_in_vector", bus.in_vector, 8'h00);

        // Masked capture, then unmask without a new edge.
        bus.req_in = 8'h81; bus.mask_in = 8'h80; step();
        chk("mask_in_vector", bus.in_vector, 8'h01);
        chk("mask_pending_raw", bus.pending_raw, 8'h81);
        bus.mask_in = 8'h00; #1;
        chk("unmask_in_vector", bus.in_vector, 8'h81);
        ack(0); step();
        ack(7); step();
        bus.ack_valid = 1'b0; bus.req_in = 8'h00; step();
        chk("clean1_pending_raw", bus.pending_raw, 8'h00);

        // New rise in the same cycle as its acknowledge: set wins, no overflow.
        bus.req_in = 8'h04; step();
        bus.req_in = 8'h00; step();
        bus.req_in = 8'h04; ack(2); step();
        bus.ack_valid = 1'b0;
        chk("setwins_pending_raw", bus.pending_raw, 8'h04);
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
        chk("setwins_overflow", bus.overflow, 8'h00);
`endif
        bus.req_in = 8'h00; ack(2); step();
        bus.ack_valid = 1'b0;
        chk("clean2_pending_raw", bus.pending_raw, 8'h00);

        // Second event on a still-pending line.
        bus.req_in = 8'h10; step();
        bus.req_in = 8'h00; step();
        bus.req_in = 8'h10; step();
        chk("lost_pending_raw", bus.pending_raw, 8'h10);
`ifdef IRQ_PENDING_LATCH_OVERFLOW_EN
        chk("lost_overflow", bus.overflow, 8'h10);
        bus.req_in = 8'h00; ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        chk("ovfclr_overflow", bus.overflow, 8'h00);
`endif
        bus.req_in = 8'h00; ack(4); step();
        bus.ack_valid = 1'b0;
        chk("clean3_pending_raw", bus.pending_raw, 8'h00);

        // Held level triggers once.
        bus.req_in = 8'h20;
        for (int i = 0; i < 10; i++) step();
        chk("held_pending_raw", bus.pending_raw, 8'h20);
        ack(5); step();
        bus.ack_valid = 1'b0;
        chk("held_ack_pending_raw", bus.pending_raw, 8'h00);
        step(); step();
        chk("held_no_retrigger", bus.pending_raw, 8'h00);

        // Acknowledge of an idle line, and of a masked pending line.
        bus.req_in = 8'h00; ack(3); step();
        bus.ack_valid = 1'b0;
        chk("idle_ack_pending_raw", bus.pending_raw, 8'h00);
        bus.req_in = 8'h02; bus.mask_in = 8'h02; step();
        chk("maskpend_in_vector", bus.in_vector, 8'h00);
        chk("maskpend_any_pending", {7'd0, bus.any_pending}, 8'h00);
        ack(1); step();
        bus.ack_valid = 1'b0; bus.mask_in = 8'h00;
        chk("maskpend_ack_raw", bus.pending_raw, 8'h00);

        // All lines pending, reset with a concurrent acknowledge, lines still high afterwards.
        bus.req_in = 8'h00; step();
        bus.req_in = 8'hFF; step();
        chk("all_pending_raw", bus.pending_raw, 8'hFF);
        rst = 1'b1; ack(0); step();
        chk("midrst_pending_raw", bus.pending_raw, 8'h00);
        chk("midrst_in_vector", bus.in_vector, 8'h00);
        chk("midrst_any_pending", {7'd0, bus.any_pending}, 8'h00);
        rst = 1'b0; bus.ack_valid = 1'b0; step();
        chk("release_pending_raw", bus.pending_raw, 8'hFF);
        step();
        chk("release_held_raw", bus.pending_raw, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
